fetch_ctrl: RTL

- Front-end fetch sequencer. Owns the pre-IF PC and issues fetches to the I-cache through a req/addr_ok/data_ok handshake.
- Drives the IF stage register's write-enable and flush.
- Applies redirects from EX (branch mispredict) and MEM (exception/ERET), with MEM taking priority.
- Discards I-cache responses that belong to fetches killed by a redirect, so IF never sees a stale instruction.

---
 rtl/fetch_ctrl_pkg.sv | 27 ++
 rtl/fetch_track_cnt.sv | 62 ++++++
 rtl/fetch_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions used by the fetch front end: reset vector, exception
// flags carried down the pipe, and the fetch sequencer states.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic Interrupt;
    logic AdEL;
    logic RI;
    logic Syscall;
    logic Break;
    logic Eret;
    logic Overflow;
  } ExceptinPipeType;

  typedef enum logic [1:0] {
    RESET,
    RUN,
    CANCEL
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_track_cnt.sv
// Tracks I-cache fetches that are accepted but unanswered, split into live
// (inflight) and killed-by-redirect (cancel) populations.
module fetch_track_cnt #(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_accept,
  input  logic             i_accept_kill,
  input  logic             i_resp,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_inflight,
  output logic [CNT_W-1:0] o_cancel,
  output logic [CNT_W-1:0] o_cancel_nxt,
  output logic             o_resp_valid
);
  import fetch_ctrl_pkg::*;

  logic [CNT_W-1:0] r_inflight, r_cancel;
  logic [CNT_W-1:0] w_inflight_nxt, w_cancel_nxt;
  logic             w_cancel_busy;

  assign w_cancel_busy = (r_cancel != '0);
  assign o_resp_valid  = i_resp & ~w_cancel_busy;

  // A redirect kills everything outstanding, including a fetch accepted in the
  // same cycle; the response arriving now retires one of them either way.
  always_comb begin
    w_inflight_nxt = r_inflight;
    w_cancel_nxt   = r_cancel;
    if (i_flush) begin
      w_inflight_nxt = '0;
      w_cancel_nxt   = r_cancel + r_inflight + CNT_W'(i_accept) - CNT_W'(i_resp);
    end else begin
      w_inflight_nxt = r_inflight + CNT_W'(i_accept & ~i_accept_kill) - CNT_W'(o_resp_valid);
      w_cancel_nxt   = r_cancel + CNT_W'(i_accept & i_accept_kill) - CNT_W'(i_resp & w_cancel_busy);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
      r_cancel   <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_cancel   <= w_cancel_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_inflight <= CNT_W'(MAX_INFLIGHT));
      assert (r_cancel <= CNT_W'(MAX_INFLIGHT));
    end
  end

  assign o_inflight   = r_inflight;
  assign o_cancel     = r_cancel;
  assign o_cancel_nxt = w_cancel_nxt;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: owns the pre-IF PC, drives the I-cache request
// handshake and IF register controls, and applies EX/MEM redirects.
//   state  | meaning
//   RESET  | one idle cycle after reset, no request
//   RUN    | normal fetching
//   CANCEL | stale responses still owed by the I-cache are being dropped
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = fetch_ctrl_pkg::RESET_PC,
  parameter int          MAX_INFLIGHT = 2,
  parameter int          CNT_W        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            MEM_Flush,
  input  logic [31:0]                     MEM_FlushPC,
  input  logic                            EXE_Redirect,
  input  logic [31:0]                     EXE_RedirectPC,
  input  logic                            ID_Stall,
  input  logic                            cpu_addr_ok,
  input  logic                            cpu_data_ok,
  output logic                            cpu_req,
  output logic [31:0]                     cpu_addr,
  output logic [31:0]                     PREIF_PC,
  output fetch_ctrl_pkg::ExceptinPipeType PREIF_ExceptType,
  output logic                            IF_Wr,
  output logic                            IF_Flush,
  output logic                            Resp_Valid
);
  import fetch_ctrl_pkg::*;

  fetch_state_t     r_state, w_state_nxt;
  logic [31:0]      r_pc, r_pend_pc;
  logic             r_pend_valid, r_req_held;
  logic [CNT_W-1:0] w_inflight, w_cancel, w_cancel_nxt;
  logic [CNT_W:0]   w_outstanding;
  logic [31:0]      w_target;
  logic             w_active, w_redirect, w_new_req, w_accept, w_hs_wait, w_resp_valid;

  assign w_active      = ~rst & (r_state != RESET);
  assign w_redirect    = w_active & (MEM_Flush | EXE_Redirect);
  assign w_target      = MEM_Flush ? MEM_FlushPC : EXE_RedirectPC;
  assign w_outstanding = {1'b0, w_inflight} + {1'b0, w_cancel};
  assign w_new_req     = w_active & ~ID_Stall
                       & (w_inflight < CNT_W'(MAX_INFLIGHT))
                       & (w_outstanding < (CNT_W+1)'(MAX_INFLIGHT));

  assign cpu_req   = w_active & (r_req_held | w_new_req);
  assign cpu_addr  = r_pc;
  assign PREIF_PC  = r_pc;
  assign w_accept  = cpu_req & cpu_addr_ok;
  // Any unaccepted request, fresh or held, must stay stable, so a redirect
  // landing on it is parked in pend_pc.
  assign w_hs_wait = cpu_req & ~cpu_addr_ok;

  assign IF_Wr      = w_accept;
  assign IF_Flush   = ~w_active | w_redirect | (w_accept & r_pend_valid);
  assign Resp_Valid = w_active & w_resp_valid;

  always_comb begin
    PREIF_ExceptType      = '0;
    PREIF_ExceptType.AdEL = is_misaligned(r_pc);
  end

  fetch_track_cnt #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CNT_W       (CNT_W)
  ) u_track (
    .clk          (clk),
    .rst          (rst),
    .i_accept     (w_accept),
    .i_accept_kill(r_pend_valid),
    .i_resp       (w_active & cpu_data_ok),
    .i_flush      (w_redirect),
    .o_inflight   (w_inflight),
    .o_cancel     (w_cancel),
    .o_cancel_nxt (w_cancel_nxt),
    .o_resp_valid (w_resp_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= RESET;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RESET:       w_state_nxt = RUN;
      RUN, CANCEL: w_state_nxt = (w_cancel_nxt != '0) ? CANCEL : RUN;
      default:     w_state_nxt = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
      r_req_held   <= 1'b0;
    end else begin
      r_req_held <= w_hs_wait;
      if (w_redirect && w_hs_wait) begin
        r_pend_pc    <= w_target;
        r_pend_valid <= 1'b1;
      end else if (w_redirect) begin
        r_pc         <= w_target;
        r_pend_valid <= 1'b0;
      end else if (w_accept && r_pend_valid) begin
        r_pc         <= r_pend_pc;
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

endmodule
